// File: rtl/p_shfrot_pkg.sv
// Shared constants, state encoding and request decode for the iterative packed shift/rotate unit.
package p_shfrot_pkg;

  localparam int unsigned PW_32 = 0;
  localparam int unsigned PW_16 = 1;
  localparam int unsigned PW_8  = 2;
  localparam int unsigned PW_4  = 3;
  localparam int unsigned PW_2  = 4;

  localparam int unsigned NUM_STAGES = 5;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic req_illegal(input logic [4:0] pw, input logic left, input logic right);
    return !$onehot(pw) || (left == right);
  endfunction

endpackage

// File: rtl/p_shfrot_stage.sv
// One barrel level (amount 2^stage) applied independently to every lane of the selected width.
module p_shfrot_stage
  import p_shfrot_pkg::*;
(
  input  logic [31:0]      data,
  input  logic [CNT_W-1:0] stage,
  input  logic [4:0]       pw,
  input  logic             rotate,
  input  logic             right,
  input  logic             enable,
  output logic [31:0]      result
);

  // Amounts >= w leave a rotated lane intact and clear a shifted lane.
  function automatic logic [31:0] lane_op(input logic [31:0] d, input int w, input int amt,
                                          input logic rot, input logic rgt);
    logic [31:0] o;
    logic [4:0]  idx;
    int          lo;
    int          j;
    int          src;
    o = '0;
    for (int i = 0; i < 32; i++) begin
      lo = i - (i % w);
      j  = i % w;
      if (amt >= w) begin
        o[i] = rot & d[i];
      end else if (rgt) begin
        src = j + amt;
        if (src < w) begin
          idx  = 5'(lo + src);
          o[i] = d[idx];
        end else begin
          idx  = 5'(lo + src - w);
          o[i] = rot & d[idx];
        end
      end else begin
        src = j - amt;
        if (src >= 0) begin
          idx  = 5'(lo + src);
          o[i] = d[idx];
        end else begin
          idx  = 5'(lo + src + w);
          o[i] = rot & d[idx];
        end
      end
    end
    return o;
  endfunction

  int amt;

  always_comb begin
    amt    = 1 << stage;
    result = data;
    if (enable) begin
      case (pw)
        5'(1 << PW_32): result = lane_op(data, 32, amt, rotate, right);
        5'(1 << PW_16): result = lane_op(data, 16, amt, rotate, right);
        5'(1 << PW_8):  result = lane_op(data, 8, amt, rotate, right);
        5'(1 << PW_4):  result = lane_op(data, 4, amt, rotate, right);
        5'(1 << PW_2):  result = lane_op(data, 2, amt, rotate, right);
        default:        result = '0;
      endcase
    end
  end

endmodule

// File: rtl/p_shfrot_iter.sv
// Handshaked packed shift/rotate: accept, five barrel stages (one per cycle), then hold the result.
module p_shfrot_iter
  import p_shfrot_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] crs1,
  input  logic [4:0]  shamt,
  input  logic [4:0]  pw,
  input  logic        rotate,
  input  logic        left,
  input  logic        right,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  state_t           state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       shamt_r;
  logic [4:0]       pw_r;
  logic             rot_r;
  logic             right_r;
  logic [7:0]       shamt_ext;
  logic [31:0]      stage_out;

  assign shamt_ext = {3'b000, shamt_r};

  p_shfrot_stage u_stage (
    .data   (acc),
    .stage  (cnt),
    .pw     (pw_r),
    .rotate (rot_r),
    .right  (right_r),
    .enable (shamt_ext[cnt]),
    .result (stage_out)
  );

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      acc       <= '0;
      cnt       <= '0;
      shamt_r   <= '0;
      pw_r      <= '0;
      rot_r     <= 1'b0;
      right_r   <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            // Illegal requests run the full latency on a zero operand so they yield zero.
            acc      <= req_illegal(pw, left, right) ? 32'd0 : crs1;
            shamt_r  <= shamt;
            pw_r     <= pw;
            rot_r    <= rotate;
            right_r  <= right;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= stage_out;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(NUM_STAGES - 1)) begin
            result    <= stage_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
